score_counter: RTL and testbench

// - Game score source for score_render (drives its num input). Counts points in packed BCD while a
//   run is active, freezes on crash, clears on the next start. Sits between player_controller
//   (start/over pulses) and the 20 Hz game tick; also emits a difficulty level for obstacle speed.

---
 rtl/score_counter.sv | 157 +++++++++++++++
 tb/tb_score_counter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// score_counter: packed-BCD game score with an IDLE/RUN/OVER run tracker and a saturating difficulty level.
// Optional feature macro SCORE_HISCORE_EN: keeps the best completed score on o_hiscore (tied to zero otherwise).
module score_counter #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 2,
  parameter int LEVEL_MAX       = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_game_tick,
  input  logic                i_game_start,
  input  logic                i_game_over,
  output logic [4*DIGITS-1:0] o_num,
  output logic                o_running,
  output logic [2:0]          o_level,
  output logic [4*DIGITS-1:0] o_hiscore
);

  localparam int             W          = 4 * DIGITS;
  localparam logic [3:0]     PRESC_LAST = 4'(TICKS_PER_POINT - 1);
  localparam logic [2:0]     LEVEL_SAT  = 3'(LEVEL_MAX);
  localparam logic [W-1:0]   ALL_NINES  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  // Ripple-carry BCD increment from digit 0 upward; a 9 becomes 0 and passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   d;
    carry = 1'b1;
    r     = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] num_q, num_d, num_inc;
  logic [3:0]   presc_q, presc_d;
  logic [2:0]   level_q, level_d;
  logic         running_q, running_d;

  assign num_inc = bcd_inc(num_q);

  // Next-state logic: start clears the run, over freezes it, ticks feed the prescaler.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    presc_d = presc_q;
    level_d = level_q;
    case (state_q)
      IDLE, OVER: begin
        if (i_game_start) begin
          state_d = RUN;
          num_d   = {W{1'b0}};
          presc_d = 4'd0;
          level_d = 3'd0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (i_game_over) begin
          state_d = OVER;
        end else if (i_game_tick) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = 4'd0;
            // At all-9s the score saturates, so neither score nor level moves.
            if (num_q != ALL_NINES) begin
              num_d = num_inc;
              if ((num_inc[7:0] == 8'h00) && (level_q < LEVEL_SAT)) begin
                level_d = level_q + 3'd1;
              end else begin
                level_d = level_q;
              end
            end else begin
              num_d = num_q;
            end
          end else begin
            presc_d = presc_q + 4'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // Run state, score, prescaler and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      num_q     <= {W{1'b0}};
      presc_q   <= 4'd0;
      level_q   <= 3'd0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      presc_q   <= presc_d;
      level_q   <= level_d;
      running_q <= running_d;
    end
  end

  assign o_num     = num_q;
  assign o_running = running_q;
  assign o_level   = level_q;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hiscore_q, hiscore_d;

  // Packed BCD orders like plain binary, so an unsigned compare picks the larger score.
  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_q == RUN) && i_game_over && (num_q > hiscore_q)) begin
      hiscore_d = num_q;
    end else begin
      hiscore_d = hiscore_q;
    end
  end

  // High score survives new runs; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_q <= {W{1'b0}};
    end else begin
      hiscore_q <= hiscore_d;
    end
  end

  assign o_hiscore = hiscore_q;
`else
  assign o_hiscore = {W{1'b0}};
`endif

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: directed scenarios plus random traffic against an integer score model.
module tb_score_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_game_tick = 1'b0;
  logic        i_game_start = 1'b0;
  logic        i_game_over = 1'b0;
  logic [15:0] o_num;
  logic        o_running;
  logic [2:0]  o_level;
  logic [15:0] o_hiscore;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integers for score, tick count and high score.
  logic m_run = 1'b0;
  int   m_score = 0;
  int   m_ticks = 0;
  int   m_hi = 0;

  int          hs_target [3] = '{42, 17, 103};
`ifdef SCORE_HISCORE_EN
  logic [15:0] hs_expect [3] = '{16'h0042, 16'h0042, 16'h0103};
`else
  logic [15:0] hs_expect [3] = '{16'h0000, 16'h0000, 16'h0000};
`endif

  score_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_game_tick  (i_game_tick),
    .i_game_start (i_game_start),
    .i_game_over  (i_game_over),
    .o_num        (o_num),
    .o_running    (o_running),
    .o_level      (o_level),
    .o_hiscore    (o_hiscore)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [35:0] exp_vec();
    int          l;
    logic [15:0] hi;
    l = m_score / 100;
    if (l > 7) l = 7;
`ifdef SCORE_HISCORE_EN
    hi = to_bcd(m_hi);
`else
    hi = 16'h0000;
`endif
    return {to_bcd(m_score), m_run, 3'(l), hi};
  endfunction

  function automatic void model_step(input logic t, input logic s, input logic o);
    if (m_run) begin
      if (o) begin
        m_run = 1'b0;
        if (m_score > m_hi) m_hi = m_score;
      end else if (t) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == 2) begin
          m_ticks = 0;
          if (m_score < 9999) m_score = m_score + 1;
        end
      end
    end else if (s) begin
      m_run   = 1'b1;
      m_score = 0;
      m_ticks = 0;
    end
  endfunction

  function automatic void model_reset();
    m_run   = 1'b0;
    m_score = 0;
    m_ticks = 0;
    m_hi    = 0;
  endfunction

  task automatic drive(input logic t, input logic s, input logic o);
    i_game_tick  = t;
    i_game_start = s;
    i_game_over  = o;
    @(posedge clk);
    model_step(t, s, o);
    #1;
    i_game_tick  = 1'b0;
    i_game_start = 1'b0;
    i_game_over  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [35:0] act;
    rst_n = 1'b0;
    model_reset();
    #3;
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== 36'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", act, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL idle_tick_ignored: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_count();
    logic [35:0] act;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      act = {o_num, o_running, o_level, o_hiscore};
      n_vec++;
      if (act !== exp_vec()) begin
        n_err++;
        $display("FAIL count_tick%0d: got %h expected %h", i, act, exp_vec());
      end
    end
    n_vec++;
    if (o_num !== 16'h0005 || o_running !== 1'b1 || o_level !== 3'd0) begin
      n_err++;
      $display("FAIL count_ten_ticks: got num=%h run=%b lvl=%0d expected num=0005 run=1 lvl=0", o_num, o_running, o_level);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h0006) begin
      n_err++;
      $display("FAIL start_in_run_ignored: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_rollover_100();
    logic [35:0] act;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 198; i++) drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (o_num !== 16'h0099 || o_level !== 3'd0) begin
      n_err++;
      $display("FAIL preload_99: got num=%h lvl=%0d expected num=0099 lvl=0", o_num, o_level);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (o_num !== 16'h0100 || o_level !== 3'd1 || act !== exp_vec()) begin
      n_err++;
      $display("FAIL rollover_100: got %h expected %h (num 0100 lvl 1)", act, exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic [35:0] act;
    logic        bad_digit;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 19998; i++) drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h9999) begin
      n_err++;
      $display("FAIL reach_9999: got %h expected %h", act, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      act = {o_num, o_running, o_level, o_hiscore};
      bad_digit = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if ($isunknown(o_num[4*d +: 4]) || o_num[4*d +: 4] > 4'd9) bad_digit = 1'b1;
      end
      n_vec++;
      if (act !== exp_vec() || o_num !== 16'h9999 || o_level !== 3'd7 || bad_digit) begin
        n_err++;
        $display("FAIL saturate_9999_tick%0d: got %h expected %h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_over_tick();
    logic [35:0] act;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 85; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h0042 || o_running !== 1'b0) begin
      n_err++;
      $display("FAIL over_beats_tick: got %h expected %h", act, exp_vec());
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, (i == 2) ? 1'b1 : 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h0042) begin
      n_err++;
      $display("FAIL over_frozen: got %h expected %h", act, exp_vec());
    end
    drive(1'b0, 1'b1, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h0000 || o_running !== 1'b1 || o_level !== 3'd0) begin
      n_err++;
      $display("FAIL restart_from_over: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_hiscore();
    logic [35:0] act;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2 * hs_target[r]; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      act = {o_num, o_running, o_level, o_hiscore};
      n_vec++;
      if (act !== exp_vec() || o_hiscore !== hs_expect[r]) begin
        n_err++;
        $display("FAIL hiscore_run%0d: got %h expected %h (hiscore %h)", r, act, exp_vec(), hs_expect[r]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [35:0] act;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 114; i++) drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (o_num !== 16'h0057) begin
      n_err++;
      $display("FAIL midrun_preload: got %h expected 0057", o_num);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== 36'h0) begin
      n_err++;
      $display("FAIL async_reset_midrun: got %h expected %h", act, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL ticks_after_reset: got %h expected %h", act, exp_vec());
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    act = {o_num, o_running, o_level, o_hiscore};
    n_vec++;
    if (act !== exp_vec() || o_num !== 16'h0001) begin
      n_err++;
      $display("FAIL start_after_reset: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [35:0] act;
    logic        t, s, o;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 39) == 0);
      o = ($urandom_range(0, 59) == 0);
      drive(t, s, o);
      act = {o_num, o_running, o_level, o_hiscore};
      n_vec++;
      if (act !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_count();
    test_rollover_100();
    test_saturation();
    test_over_tick();
    test_hiscore();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
